// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches an instruction, decodes control flow and
// issues one registered PC update strobe per instruction until HALT.
module pc_sequencer #(
    parameter int unsigned PC_BITS    = 6,
    parameter int unsigned INSTR_BITS = 16,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic [INSTR_BITS-1:0] instr,
    input  logic                  instr_valid,
    input  logic                  zero_flag,
    input  logic                  neg_flag,
    output logic                  fetch_req,
    output logic                  pc_latch_data,
    output logic [1:0]            pc_ctl,
    output logic [PC_BITS-1:0]    imm,
    output logic [2:0]            sr1_addr,
    output logic                  halted,
    output logic [CNT_BITS-1:0]   retired
);

    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_RST  = 4'hB;

    localparam logic [1:0] CTL_INC = 2'b00;
    localparam logic [1:0] CTL_REL = 2'b01;
    localparam logic [1:0] CTL_REG = 2'b10;
    localparam logic [1:0] CTL_ZERO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_UPDATE,
        S_HALT
    } state_t;

    state_t                r_state;
    logic [INSTR_BITS-1:0] r_ir;

    logic [3:0]            w_opcode;
    logic [1:0]            w_cond;
    logic [2:0]            w_reg;
    logic [5:0]            w_off;
    logic                  w_taken;
    logic [1:0]            w_ctl;
    logic [PC_BITS-1:0]    w_imm;
    logic [2:0]            w_sr1;
    logic                  w_unused;

    assign w_opcode = r_ir[15:12];
    assign w_cond   = r_ir[11:10];
    assign w_reg    = r_ir[8:6];
    assign w_off    = r_ir[5:0];
    assign w_unused = r_ir[9];

    // Branch condition evaluated against the live flags; only consumed on the DECODE edge.
    always_comb begin
        w_taken = 1'b0;
        case (w_cond)
            2'b00:   w_taken = 1'b1;
            2'b01:   w_taken = zero_flag;
            2'b10:   w_taken = neg_flag;
            default: w_taken = ~zero_flag;
        endcase
    end

    always_comb begin
        w_ctl = CTL_INC;
        w_imm = '0;
        w_sr1 = 3'd0;
        case (w_opcode)
            OP_BR: begin
                if (w_taken) begin
                    w_ctl = CTL_REL;
                    w_imm = PC_BITS'(w_off);
                end
            end
            OP_JMP: begin
                w_ctl = CTL_REG;
                w_sr1 = w_reg;
            end
            OP_RST:  w_ctl = CTL_ZERO;
            default: w_ctl = CTL_INC;
        endcase
    end

    // Sequencer FSM; every output is a register written here.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ir          <= '0;
            fetch_req     <= 1'b0;
            pc_latch_data <= 1'b0;
            pc_ctl        <= CTL_INC;
            imm           <= '0;
            sr1_addr      <= 3'd0;
            halted        <= 1'b0;
            retired       <= '0;
        end else begin
            pc_latch_data <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    fetch_req <= 1'b1;
                    r_state   <= S_FETCH;
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        r_ir      <= instr;
                        fetch_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_opcode == OP_HALT) begin
                        halted  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        pc_ctl        <= w_ctl;
                        imm           <= w_imm;
                        sr1_addr      <= w_sr1;
                        pc_latch_data <= 1'b1;
                        r_state       <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    retired   <= retired + CNT_BITS'(1);
                    fetch_req <= 1'b1;
                    r_state   <= S_FETCH;
                end
                S_HALT: begin
                    halted    <= 1'b1;
                    fetch_req <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with a 4-bit counter covers wrap.
module tb_pc_sequencer;

    logic        clka = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        zero_flag = 1'b0;
    logic        neg_flag = 1'b0;

    logic        fetch_req, pc_latch_data, halted;
    logic [1:0]  pc_ctl;
    logic [5:0]  imm;
    logic [2:0]  sr1_addr;
    logic [15:0] retired;

    logic        fetch_req4, pc_latch_data4, halted4;
    logic [1:0]  pc_ctl4;
    logic [5:0]  imm4;
    logic [2:0]  sr1_addr4;
    logic [3:0]  retired4;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    logic        o_dec_latch, o_dec_fetch, o_upd_latch, o_aft_latch, o_aft_fetch;
    logic [1:0]  o_ctl;
    logic [5:0]  o_imm;
    logic [2:0]  o_sr1;
    logic [15:0] o_ret;

    always #5 clka = ~clka;

    pc_sequencer #(.PC_BITS(6), .INSTR_BITS(16), .CNT_BITS(16)) u_dut (
        .clka(clka), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .zero_flag(zero_flag), .neg_flag(neg_flag), .fetch_req(fetch_req),
        .pc_latch_data(pc_latch_data), .pc_ctl(pc_ctl), .imm(imm),
        .sr1_addr(sr1_addr), .halted(halted), .retired(retired)
    );

    pc_sequencer #(.PC_BITS(6), .INSTR_BITS(16), .CNT_BITS(4)) u_dut4 (
        .clka(clka), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .zero_flag(zero_flag), .neg_flag(neg_flag), .fetch_req(fetch_req4),
        .pc_latch_data(pc_latch_data4), .pc_ctl(pc_ctl4), .imm(imm4),
        .sr1_addr(sr1_addr4), .halted(halted4), .retired(retired4)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Leaves both DUTs in FETCH, one sample point after the IDLE edge.
    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        exp_ret = 0;
    endtask

    // One instruction from FETCH: flags at the FETCH edge differ from those at the DECODE edge,
    // and a HALT word is offered with valid during DECODE to show it is ignored.
    task automatic run_instr(input logic [15:0] w, input logic z_f, input logic n_f,
                             input logic z_d, input logic n_d);
        instr = w; instr_valid = 1'b1; zero_flag = z_f; neg_flag = n_f;
        tick();
        o_dec_latch = pc_latch_data; o_dec_fetch = fetch_req;
        instr = 16'hE000; instr_valid = 1'b1; zero_flag = z_d; neg_flag = n_d;
        tick();
        o_upd_latch = pc_latch_data; o_ctl = pc_ctl; o_imm = imm; o_sr1 = sr1_addr;
        instr_valid = 1'b0; zero_flag = ~z_d; neg_flag = ~n_d;
        tick();
        o_aft_latch = pc_latch_data; o_aft_fetch = fetch_req; o_ret = retired;
        exp_ret = exp_ret + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr = 16'h0000; instr_valid = 1'b1;
        tick();
        tick();
        n_checks++; if ({fetch_req, pc_latch_data, pc_ctl, imm, sr1_addr, halted} !== 13'd0) begin
            n_fail++; $display("FAIL reset_outputs got %b expected 0", {fetch_req, pc_latch_data, pc_ctl, imm, sr1_addr, halted}); end
        n_checks++; if (retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired got %0d expected 0", retired); end
        reset = 1'b0;
        tick();
        n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL startup_fetch_req got %b expected 1", fetch_req); end
        exp_ret = 0;
        run_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_dec_latch !== 1'b0 || o_dec_fetch !== 1'b0) begin
            n_fail++; $display("FAIL startup_decode latch=%b fetch=%b expected 0 0", o_dec_latch, o_dec_fetch); end
        n_checks++; if (o_upd_latch !== 1'b1 || o_ctl !== 2'b00) begin
            n_fail++; $display("FAIL startup_update latch=%b ctl=%b expected 1 00", o_upd_latch, o_ctl); end
        n_checks++; if (o_aft_latch !== 1'b0 || o_aft_fetch !== 1'b1 || o_ret !== 16'd1) begin
            n_fail++; $display("FAIL startup_after latch=%b fetch=%b retired=%0d expected 0 1 1", o_aft_latch, o_aft_fetch, o_ret); end
    endtask

    task automatic test_branch();
        run_instr(16'hC005, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_upd_latch !== 1'b1 || o_ctl !== 2'b01 || o_imm !== 6'd5) begin
            n_fail++; $display("FAIL br_always latch=%b ctl=%b imm=%0d expected 1 01 5", o_upd_latch, o_ctl, o_imm); end
        n_checks++; if (o_aft_latch !== 1'b0) begin n_fail++; $display("FAIL br_strobe_width got %b expected 0", o_aft_latch); end
        // zero_flag high at the FETCH edge but low at the DECODE edge: not taken
        run_instr(16'hC405, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_ctl !== 2'b00 || o_imm !== 6'd0) begin
            n_fail++; $display("FAIL br_zero_not_taken ctl=%b imm=%0d expected 00 0", o_ctl, o_imm); end
        run_instr(16'hC405, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (o_ctl !== 2'b01 || o_imm !== 6'd5) begin
            n_fail++; $display("FAIL br_zero_taken ctl=%b imm=%0d expected 01 5", o_ctl, o_imm); end
        run_instr(16'hC82A, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (o_ctl !== 2'b01 || o_imm !== 6'h2A) begin
            n_fail++; $display("FAIL br_neg_taken ctl=%b imm=%h expected 01 2a", o_ctl, o_imm); end
        run_instr(16'hCC07, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (o_ctl !== 2'b00 || o_imm !== 6'd0) begin
            n_fail++; $display("FAIL br_nz_not_taken ctl=%b imm=%0d expected 00 0", o_ctl, o_imm); end
        run_instr(16'hCC3F, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_ctl !== 2'b01 || o_imm !== 6'h3F) begin
            n_fail++; $display("FAIL br_nz_taken ctl=%b imm=%h expected 01 3f", o_ctl, o_imm); end
    endtask

    task automatic test_jump();
        run_instr(16'hD0C0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_upd_latch !== 1'b1 || o_ctl !== 2'b10 || o_sr1 !== 3'd3 || o_imm !== 6'd0) begin
            n_fail++; $display("FAIL jmp latch=%b ctl=%b sr1=%0d imm=%0d expected 1 10 3 0", o_upd_latch, o_ctl, o_sr1, o_imm); end
        run_instr(16'hB000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (o_upd_latch !== 1'b1 || o_ctl !== 2'b11 || o_imm !== 6'd0) begin
            n_fail++; $display("FAIL rst_op latch=%b ctl=%b imm=%0d expected 1 11 0", o_upd_latch, o_ctl, o_imm); end
        n_checks++; if (o_ret !== 16'(exp_ret)) begin n_fail++; $display("FAIL jump_retired got %0d expected %0d", o_ret, exp_ret); end
    endtask

    task automatic test_mem_wait();
        int bad;
        bad = 0;
        instr = 16'hE000; instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fetch_req !== 1'b1 || pc_latch_data !== 1'b0 || halted !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wait_hold bad_cycles=%0d expected 0", bad); end
        instr = 16'hC003; instr_valid = 1'b1;
        tick();
        n_checks++; if (pc_latch_data !== 1'b0 || fetch_req !== 1'b0) begin
            n_fail++; $display("FAIL wait_decode latch=%b fetch=%b expected 0 0", pc_latch_data, fetch_req); end
        instr_valid = 1'b0;
        tick();
        n_checks++; if (pc_latch_data !== 1'b1 || pc_ctl !== 2'b01 || imm !== 6'd3) begin
            n_fail++; $display("FAIL wait_update latch=%b ctl=%b imm=%0d expected 1 01 3", pc_latch_data, pc_ctl, imm); end
        tick();
        exp_ret = exp_ret + 1;
        n_checks++; if (retired !== 16'(exp_ret) || pc_latch_data !== 1'b0) begin
            n_fail++; $display("FAIL wait_retired got %0d latch=%b expected %0d 0", retired, pc_latch_data, exp_ret); end
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        instr = 16'hE000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        n_checks++; if (halted !== 1'b1 || pc_latch_data !== 1'b0 || fetch_req !== 1'b0 || retired !== 16'(exp_ret)) begin
            n_fail++; $display("FAIL halt_enter halted=%b latch=%b fetch=%b retired=%0d expected 1 0 0 %0d",
                               halted, pc_latch_data, fetch_req, retired, exp_ret); end
        for (int i = 0; i < 6; i++) begin
            instr = 16'h0000; instr_valid = i[0];
            tick();
            if (halted !== 1'b1 || pc_latch_data !== 1'b0 || fetch_req !== 1'b0 || retired !== 16'(exp_ret)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL halt_sticky bad_cycles=%0d expected 0", bad); end
        do_reset();
        n_checks++; if (halted !== 1'b0 || fetch_req !== 1'b1) begin
            n_fail++; $display("FAIL halt_exit halted=%b fetch=%b expected 0 1", halted, fetch_req); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        instr = 16'hD0C0; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        n_checks++; if (pc_latch_data !== 1'b1 || retired !== 16'd1 || pc_ctl !== 2'b10 || sr1_addr !== 3'd3) begin
            n_fail++; $display("FAIL mid_pre latch=%b retired=%0d ctl=%b sr1=%0d expected 1 1 10 3",
                               pc_latch_data, retired, pc_ctl, sr1_addr); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (pc_latch_data !== 1'b0 || retired !== 16'd0 || pc_ctl !== 2'b00 || sr1_addr !== 3'd0 || fetch_req !== 1'b0) begin
            n_fail++; $display("FAIL mid_async latch=%b retired=%0d ctl=%b sr1=%0d fetch=%b expected 0 0 00 0 0",
                               pc_latch_data, retired, pc_ctl, sr1_addr, fetch_req); end
        do_reset();
    endtask

    task automatic test_back_to_back_wrap();
        int dbl;
        logic prev;
        dbl = 0;
        prev = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            instr = 16'h1234; instr_valid = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (c == 0) instr_valid = 1'b0;
                if (pc_latch_data === 1'b1 && prev === 1'b1) dbl++;
                prev = pc_latch_data;
            end
            if (i == 14) begin
                n_checks++; if (retired4 !== 4'd15) begin n_fail++; $display("FAIL cnt4_at15 got %0d expected 15", retired4); end
            end
        end
        n_checks++; if (dbl != 0) begin n_fail++; $display("FAIL strobe_consecutive count=%0d expected 0", dbl); end
        n_checks++; if (retired4 !== 4'd0) begin n_fail++; $display("FAIL cnt4_wrap got %0d expected 0", retired4); end
        n_checks++; if (retired !== 16'd16) begin n_fail++; $display("FAIL cnt16_16 got %0d expected 16", retired); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_mem_wait();
        test_halt();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
